// File: rtl/alu_share_pkg.sv
// -----------------------------------------------------------------------------
// alu_share_pkg
// Shared types and helpers for the ALU-sharing scheduler.
//  - state_t   : scheduler FSM states.
//  - OP_*      : 4-bit ALU op codes, taken from the shared controls.sv macros.
//  - slice_of  : extracts requester i's field from a flattened request bus.
// -----------------------------------------------------------------------------
package alu_share_pkg;

`include "controls.sv"

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Op codes re-exported as typed constants so that modules and benches do
  // not have to expand the raw macros at every use.
  localparam logic [3:0] OP_ADD = `ALU_ADD;
  localparam logic [3:0] OP_SUB = `ALU_SUB;
  localparam logic [3:0] OP_AND = `ALU_AND;
  localparam logic [3:0] OP_OR  = `ALU_OR;
  localparam logic [3:0] OP_XOR = `ALU_XOR;
  localparam logic [3:0] OP_MUL = `ALU_MUL;

  // Upper bounds for the flattened buses handled by slice_of: up to 8
  // requesters with fields up to 64 bits wide.
  localparam int SLICE_MAX_W = 64;
  localparam int SLICE_MAX_N = 8;
  localparam int BUS_MAX_W   = SLICE_MAX_W * SLICE_MAX_N;

  // Returns bus[idx*w +: w] in the low bits. Bits above w belong to the
  // following slices, so the caller truncates the result to its field width.
  function automatic logic [SLICE_MAX_W-1:0] slice_of(
    input logic [BUS_MAX_W-1:0] bus,
    input int unsigned          idx,
    input int unsigned          w
  );
    logic [BUS_MAX_W-1:0] shifted;
    shifted = bus >> (idx * w);
    return shifted[SLICE_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/controls.sv
// -----------------------------------------------------------------------------
// controls.sv
// Shared ALU operation-code macros used by every block that talks to the ALU.
// Any code not listed here is undefined; the ALU returns 0 for it.
// -----------------------------------------------------------------------------
`ifndef CONTROLS_SV
`define CONTROLS_SV

`define ALU_ADD 4'h0
`define ALU_SUB 4'h1
`define ALU_AND 4'h2
`define ALU_OR  4'h3
`define ALU_XOR 4'h4
`define ALU_SLL 4'h5
`define ALU_SRL 4'h6
`define ALU_SRA 4'h7
`define ALU_SLT 4'h8
`define ALU_MUL 4'h9

`endif

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Scans req starting at ptr and
// wrapping modulo N; the first asserted request wins.
// Ports:
//   req       in  N          request vector
//   ptr       in  clog2(N)   highest-priority index (must be < N)
//   grant     out N          one-hot grant (all zero when no request)
//   grant_idx out clog2(N)   index of the granted requester
//   any_req   out 1          at least one request is asserted
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any_req
);

  localparam int IDX_W = $clog2(N);
  // One extra bit so ptr + k cannot overflow before the modulo-N fold.
  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path through
    // this block leaves a variable unassigned and no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + SUM_W'(k);
      if (sum >= SUM_W'(N)) begin
        sum = sum - SUM_W'(N);
      end
      idx = sum[IDX_W-1:0];
      if (!any_req && req[idx]) begin
        any_req    = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/alu_share_sched.sv
// -----------------------------------------------------------------------------
// alu_share_sched
// Time-shares one external combinational ALU among NREQ requesters.
// A request is accepted in IDLE (round-robin), its operands are registered
// and held on the ALU inputs for one EXEC cycle (MUL_LAT cycles for ALU_MUL),
// then the registered result is offered to the owner in RESP until accepted.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    per-requester request handshake (NREQ bits)
//   req_a/req_b/req_sel    flattened per-requester operands and op select
//   resp_valid/resp_ready  per-requester response handshake (NREQ bits)
//   resp_out/zero/neg      registered result and flags, shared by requesters
//   alu_a/alu_b/alu_sel    registered drive to the external ALU
//   alu_out/zero/neg       combinational return from the external ALU
//   busy                   scheduler is not IDLE
// -----------------------------------------------------------------------------
module alu_share_sched
  import alu_share_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ALU_SEL = 4,
  parameter int NREQ    = 2,
  parameter int MUL_LAT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ*ALU_SEL-1:0] req_sel,
  output logic [NREQ-1:0]         resp_valid,
  input  logic [NREQ-1:0]         resp_ready,
  output logic [WIDTH-1:0]        resp_out,
  output logic                    resp_zero,
  output logic                    resp_neg,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  output logic [ALU_SEL-1:0]      alu_sel,
  input  logic [WIDTH-1:0]        alu_out,
  input  logic                    alu_zero,
  input  logic                    alu_neg,
  output logic                    busy
);

  localparam int IDX_W = $clog2(NREQ);
  // Wide enough to hold MUL_LAT-1; at least one bit.
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  localparam logic [ALU_SEL-1:0] SEL_MUL  = ALU_SEL'(OP_MUL);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NREQ - 1);
  localparam logic [CNT_W-1:0]   MUL_CNT  = CNT_W'(MUL_LAT - 1);

  state_t             state_q,  state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q,  owner_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   a_q,      a_d;
  logic [WIDTH-1:0]   b_q,      b_d;
  logic [ALU_SEL-1:0] sel_q,    sel_d;
  logic [WIDTH-1:0]   res_q,    res_d;
  logic               zero_q,   zero_d;
  logic               neg_q,    neg_d;

  logic [NREQ-1:0]    arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  logic [WIDTH-1:0]   pick_a;
  logic [WIDTH-1:0]   pick_b;
  logic [ALU_SEL-1:0] pick_sel;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  // Operand fields of whichever requester the arbiter currently selects.
  assign pick_a   = WIDTH'(slice_of(BUS_MAX_W'(req_a), 32'(arb_idx), 32'(WIDTH)));
  assign pick_b   = WIDTH'(slice_of(BUS_MAX_W'(req_b), 32'(arb_idx), 32'(WIDTH)));
  assign pick_sel = ALU_SEL'(slice_of(BUS_MAX_W'(req_sel), 32'(arb_idx), 32'(ALU_SEL)));

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    res_d    = res_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          a_d     = pick_a;
          b_d     = pick_b;
          sel_d   = pick_sel;
          owner_d = arb_idx;
          // The multiplier gets MUL_LAT cycles of stable inputs; everything
          // else resolves in one.
          cnt_d   = (pick_sel == SEL_MUL) ? MUL_CNT : '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          res_d   = alu_out;
          zero_d  = alu_zero;
          neg_d   = alu_neg;
          state_d = RESP;
        end
      end
      RESP: begin
        // Only the owner's resp_ready completes the response.
        if (resp_ready[owner_q]) begin
          rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  // Handshakes are masked during reset so a requester never sees an accept
  // or a response that the reset is about to discard.
  assign req_ready = (state_q == IDLE && !rst) ? arb_grant : '0;

  always_comb begin
    resp_valid = '0;
    if (state_q == RESP && !rst) begin
      resp_valid[owner_q] = 1'b1;
    end
  end

  assign resp_out  = res_q;
  assign resp_zero = zero_q;
  assign resp_neg  = neg_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_share_sched
// Directed bench for alu_share_sched. Two instances: a 2-requester one with
// MUL_LAT=3 and a 4-requester one with MUL_LAT=1, each wired to a small
// behavioural ALU. Inputs change on the falling edge; outputs are sampled
// 1 ns later, half a period away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_alu_share_sched;
  import alu_share_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] sel);
    case (sel)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_MUL:  return a * b;
      default: return '0;
    endcase
  endfunction

  // ---------------- 2-requester instance ----------------
  logic [1:0]     r2_valid, r2_ready, p2_valid, p2_ready;
  logic [2*W-1:0] r2_a, r2_b;
  logic [7:0]     r2_sel;
  logic [W-1:0]   p2_out, a2_a, a2_b, a2_out;
  logic [3:0]     a2_sel;
  logic           p2_zero, p2_neg, a2_zero, a2_neg, busy2;

  always_comb begin
    a2_out  = alu_model(a2_a, a2_b, a2_sel);
    a2_zero = (a2_out == '0);
    a2_neg  = a2_out[W-1];
  end

  alu_share_sched #(.WIDTH(W), .ALU_SEL(4), .NREQ(2), .MUL_LAT(3)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(r2_valid), .req_ready(r2_ready),
    .req_a(r2_a), .req_b(r2_b), .req_sel(r2_sel),
    .resp_valid(p2_valid), .resp_ready(p2_ready),
    .resp_out(p2_out), .resp_zero(p2_zero), .resp_neg(p2_neg),
    .alu_a(a2_a), .alu_b(a2_b), .alu_sel(a2_sel),
    .alu_out(a2_out), .alu_zero(a2_zero), .alu_neg(a2_neg),
    .busy(busy2)
  );

  // ---------------- 4-requester instance ----------------
  logic [3:0]     r4_valid, r4_ready, p4_valid, p4_ready;
  logic [4*W-1:0] r4_a, r4_b;
  logic [15:0]    r4_sel;
  logic [W-1:0]   p4_out, a4_a, a4_b, a4_out;
  logic [3:0]     a4_sel;
  logic           p4_zero, p4_neg, a4_zero, a4_neg, busy4;

  always_comb begin
    a4_out  = alu_model(a4_a, a4_b, a4_sel);
    a4_zero = (a4_out == '0);
    a4_neg  = a4_out[W-1];
  end

  alu_share_sched #(.WIDTH(W), .ALU_SEL(4), .NREQ(4), .MUL_LAT(1)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid(r4_valid), .req_ready(r4_ready),
    .req_a(r4_a), .req_b(r4_b), .req_sel(r4_sel),
    .resp_valid(p4_valid), .resp_ready(p4_ready),
    .resp_out(p4_out), .resp_zero(p4_zero), .resp_neg(p4_neg),
    .alu_a(a4_a), .alu_b(a4_b), .alu_sel(a4_sel),
    .alu_out(a4_out), .alu_zero(a4_zero), .alu_neg(a4_neg),
    .busy(busy4)
  );

  logic [1:0] exp_oh2;
  logic [3:0] exp_oh4;
  int         exp_idx;

  initial begin
    rst      = 1'b1;
    r2_valid = '0; r2_a = '0; r2_b = '0; r2_sel = '0; p2_ready = '0;
    r4_valid = '0; r4_a = '0; r4_b = '0; r4_sel = '0; p4_ready = '0;

    // ---- reset ----
    @(negedge clk); r2_valid = 2'b01; #1;
    check("rst_req_ready", r2_ready, 2'b00);
    @(negedge clk); r2_valid = '0; rst = 1'b0; #1;
    check("rst_busy",       busy2,    0);
    check("rst_resp_valid", p2_valid, 2'b00);
    check("rst_resp_out",   p2_out,   0);
    check("rst_alu_a",      a2_a,     0);
    check("rst_alu_sel",    a2_sel,   0);
    check("rst_busy4",      busy4,    0);

    // ---- single ADD 5+7 from requester 0 ----
    @(negedge clk);
    r2_a[0 +: W] = 5; r2_b[0 +: W] = 7; r2_sel[0 +: 4] = OP_ADD; r2_valid = 2'b01; #1;
    check("add_req_ready", r2_ready, 2'b01);
    @(negedge clk); r2_valid = '0; #1;
    check("add_exec_busy",    busy2,    1);
    check("add_exec_alu_a",   a2_a,     5);
    check("add_exec_alu_b",   a2_b,     7);
    check("add_exec_no_resp", p2_valid, 2'b00);
    @(negedge clk); p2_ready = 2'b01; #1;
    check("add_resp_valid", p2_valid, 2'b01);
    check("add_resp_out",   p2_out,   12);
    check("add_resp_zero",  p2_zero,  0);
    check("add_resp_neg",   p2_neg,   0);
    @(negedge clk); #1;
    check("add_idle_busy", busy2, 0);

    // ---- MUL 6*7 from requester 1, MUL_LAT=3 ----
    @(negedge clk);
    r2_a[W +: W] = 6; r2_b[W +: W] = 7; r2_sel[4 +: 4] = OP_MUL;
    r2_valid = 2'b10; p2_ready = 2'b11; #1;
    check("mul_req_ready", r2_ready, 2'b10);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); r2_valid = '0; #1;
      check($sformatf("mul_alu_a_n%0d", k),   a2_a,     6);
      check($sformatf("mul_alu_b_n%0d", k),   a2_b,     7);
      check($sformatf("mul_alu_sel_n%0d", k), a2_sel,   OP_MUL);
      check($sformatf("mul_no_resp_n%0d", k), p2_valid, 2'b00);
    end
    @(negedge clk); #1;
    check("mul_resp_valid", p2_valid, 2'b10);
    check("mul_resp_out",   p2_out,   42);

    // ---- contention: both requesters valid, grants alternate 0,1,0,1 ----
    @(negedge clk);
    r2_a[0 +: W] = 3; r2_b[0 +: W] = 3; r2_sel[0 +: 4] = OP_SUB;
    r2_a[W +: W] = 1; r2_b[W +: W] = 2; r2_sel[4 +: 4] = OP_SUB;
    r2_valid = 2'b11; p2_ready = 2'b11;
    for (int op = 0; op < 4; op++) begin
      exp_oh2 = (op % 2 == 0) ? 2'b01 : 2'b10;
      if (op > 0) @(negedge clk);
      #1;
      check($sformatf("rot_grant_%0d", op), r2_ready, exp_oh2);
      @(negedge clk); #1;
      @(negedge clk); #1;
      check($sformatf("rot_resp_valid_%0d", op), p2_valid, exp_oh2);
      check($sformatf("rot_resp_out_%0d", op),   p2_out,  (op % 2 == 0) ? 32'h0 : 32'hFFFF_FFFF);
      check($sformatf("rot_resp_zero_%0d", op),  p2_zero, (op % 2 == 0) ? 1 : 0);
      check($sformatf("rot_resp_neg_%0d", op),   p2_neg,  (op % 2 == 0) ? 0 : 1);
    end
    @(negedge clk); r2_valid = '0; p2_ready = '0;

    // ---- response backpressure on requester 0 ----
    @(negedge clk);
    r2_a[0 +: W] = 2; r2_b[0 +: W] = 5; r2_sel[0 +: 4] = OP_SUB; r2_valid = 2'b01; #1;
    check("bp_req_ready", r2_ready, 2'b01);
    @(negedge clk);
    r2_a[W +: W] = 5; r2_b[W +: W] = 7; r2_sel[4 +: 4] = OP_ADD; r2_valid = 2'b10; #1;
    check("bp_exec_req_ready", r2_ready, 2'b00);
    for (int k = 0; k < 5; k++) begin
      // Non-owner ready is asserted and must be ignored.
      @(negedge clk); p2_ready = 2'b10; #1;
      check($sformatf("bp_hold_valid_%0d", k), p2_valid, 2'b01);
      check($sformatf("bp_hold_out_%0d", k),   p2_out,   32'hFFFF_FFFD);
      check($sformatf("bp_hold_neg_%0d", k),   p2_neg,   1);
      check($sformatf("bp_hold_zero_%0d", k),  p2_zero,  0);
      check($sformatf("bp_hold_ready_%0d", k), r2_ready, 2'b00);
    end
    @(negedge clk); p2_ready = 2'b01; #1;
    check("bp_release_valid", p2_valid, 2'b01);
    check("bp_release_ready", r2_ready, 2'b00);
    @(negedge clk); p2_ready = 2'b11; #1;
    check("bp_next_grant",   r2_ready, 2'b10);
    check("bp_next_novalid", p2_valid, 2'b00);
    @(negedge clk); r2_valid = '0; #1;
    @(negedge clk); #1;
    check("bp_r1_valid", p2_valid, 2'b10);
    check("bp_r1_out",   p2_out,   12);
    @(negedge clk); p2_ready = '0;

    // ---- reset during EXEC of a MUL ----
    @(negedge clk);
    r2_a[0 +: W] = 6; r2_b[0 +: W] = 7; r2_sel[0 +: 4] = OP_MUL; r2_valid = 2'b01; #1;
    check("rm_req_ready", r2_ready, 2'b01);
    @(negedge clk); r2_valid = '0; rst = 1'b1; #1;
    check("rm_exec_busy", busy2, 1);
    @(negedge clk); rst = 1'b0; #1;
    check("rm_after_busy",  busy2,    0);
    check("rm_after_valid", p2_valid, 2'b00);
    check("rm_after_alu_a", a2_a,     0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); p2_ready = 2'b11; #1;
      check($sformatf("rm_no_resp_%0d", k), p2_valid, 2'b00);
    end
    @(negedge clk);
    r2_a[0 +: W] = 32'hF0; r2_b[0 +: W] = 32'h0F; r2_sel[0 +: 4] = OP_OR; r2_valid = 2'b01; #1;
    check("rm_or_req_ready", r2_ready, 2'b01);
    @(negedge clk); r2_valid = '0; #1;
    @(negedge clk); #1;
    check("rm_or_valid", p2_valid, 2'b01);
    check("rm_or_out",   p2_out,   32'hFF);
    check("rm_or_zero",  p2_zero,  0);
    @(negedge clk); p2_ready = '0;

    // ---- NREQ=4: move rr_ptr to 2 with one op from requester 1 ----
    @(negedge clk);
    r4_a[W +: W] = 1; r4_b[W +: W] = 1; r4_sel[4 +: 4] = OP_ADD; r4_valid = 4'b0010; p4_ready = 4'b1111; #1;
    check("n4_setup_grant", r4_ready, 4'b0010);
    @(negedge clk); r4_valid = '0; #1;
    @(negedge clk); #1;
    check("n4_setup_valid", p4_valid, 4'b0010);
    check("n4_setup_out",   p4_out,   2);

    // ---- NREQ=4: sparse requesters 3 and 0, grants 3,0,3,0 ----
    @(negedge clk);
    r4_a[3*W +: W] = 3; r4_b[3*W +: W] = 0; r4_sel[12 +: 4] = OP_ADD;
    r4_a[0 +: W]   = 0; r4_b[0 +: W]   = 0; r4_sel[0 +: 4]  = OP_ADD;
    r4_valid = 4'b1001;
    for (int op = 0; op < 4; op++) begin
      exp_idx = (op % 2 == 0) ? 3 : 0;
      exp_oh4 = 4'b0001 << exp_idx;
      if (op > 0) @(negedge clk);
      #1;
      check($sformatf("wrap_grant_%0d", op), r4_ready, exp_oh4);
      @(negedge clk); #1;
      @(negedge clk); #1;
      check($sformatf("wrap_resp_valid_%0d", op), p4_valid, exp_oh4);
      check($sformatf("wrap_resp_out_%0d", op),   p4_out,  (exp_idx == 3) ? 3 : 0);
      check($sformatf("wrap_resp_zero_%0d", op),  p4_zero, (exp_idx == 3) ? 0 : 1);
    end
    @(negedge clk); r4_valid = '0;

    // ---- NREQ=4, MUL_LAT=1: MUL resolves in a single EXEC cycle ----
    @(negedge clk);
    r4_a[2*W +: W] = 6; r4_b[2*W +: W] = 7; r4_sel[8 +: 4] = OP_MUL; r4_valid = 4'b0100; #1;
    check("m1_grant", r4_ready, 4'b0100);
    @(negedge clk); r4_valid = '0; #1;
    check("m1_exec_no_resp", p4_valid, 4'b0000);
    check("m1_exec_alu_sel", a4_sel,   OP_MUL);
    @(negedge clk); #1;
    check("m1_resp_valid", p4_valid, 4'b0100);
    check("m1_resp_out",   p4_out,   42);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
